// File: rtl/alu_seq_addsub.sv
// Multi-cycle add/sub/and-not/xor unit for EX: decodes instr into operand inversion,
// carry-in and op class, then ripples through the operands CHUNK bits per cycle.
module alu_seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      instr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             inv_a,
    output logic             inv_b,
    output logic             cin
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {CLS_ADD = 2'd0, CLS_AND = 2'd1, CLS_XOR = 2'd2} cls_t;
    typedef struct packed {
        logic inv_a;
        logic inv_b;
        logic cin;
        cls_t cls;
    } dec_t;

    function automatic dec_t decode(input logic [15:0] iw);
        logic [4:0] op;
        logic [1:0] fn;
        logic       rr;
        dec_t       d;
        op      = iw[15:11];
        fn      = iw[1:0];
        rr      = (op == 5'b11011);
        d.inv_a = 1'b0;
        d.inv_b = 1'b0;
        d.cin   = 1'b0;
        d.cls   = CLS_ADD;
        if (op == 5'b01001 || (rr && fn == 2'b01)) begin
            d.inv_a = 1'b1;
            d.cin   = 1'b1;
        end else if (op == 5'b01011 || (rr && fn == 2'b11)) begin
            d.inv_b = 1'b1;
            d.cls   = CLS_AND;
        end else if (op == 5'b01010 || (rr && fn == 2'b10)) begin
            d.cls   = CLS_XOR;
        end
        return d;
    endfunction

    // Upper bit of the return value is the carry leaving the chunk.
    function automatic logic [CHUNK:0] chunk_op(input cls_t             c_cls,
                                                input logic [CHUNK-1:0] x,
                                                input logic [CHUNK-1:0] y,
                                                input logic             c);
        case (c_cls)
            CLS_AND: chunk_op = {c, x & y};
            CLS_XOR: chunk_op = {c, x ^ y};
            default: chunk_op = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
        endcase
    endfunction

    state_t          state;
    cls_t            cls;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic            carry;
    logic [IDXW-1:0] idx;

    dec_t            dec_in;
    logic            accept;
    logic [CHUNK:0]  step;
    logic [WIDTH-1:0] result_nxt;
    logic            ovf_nxt;

    assign dec_in   = decode(instr);
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready & ~flush;

    // opa/opb shift right each BUSY cycle, so the active chunk is always the low one.
    assign step       = chunk_op(cls, opa[CHUNK-1:0], opb[CHUNK-1:0], carry);
    assign result_nxt = result | (WIDTH'(step[CHUNK-1:0]) << (int'(idx) * CHUNK));
    assign ovf_nxt    = (cls == CLS_ADD) & (opa[CHUNK-1] == opb[CHUNK-1])
                        & (step[CHUNK-1] != opa[CHUNK-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cls       <= CLS_ADD;
            opa       <= '0;
            opb       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            inv_a     <= 1'b0;
            inv_b     <= 1'b0;
            cin       <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        opa       <= dec_in.inv_a ? ~a : a;
                        opb       <= dec_in.inv_b ? ~b : b;
                        carry     <= dec_in.cin;
                        cls       <= dec_in.cls;
                        inv_a     <= dec_in.inv_a;
                        inv_b     <= dec_in.inv_b;
                        cin       <= dec_in.cin;
                        idx       <= '0;
                        result    <= '0;
                        out_valid <= 1'b0;
                        cout      <= 1'b0;
                        ovf       <= 1'b0;
                        zero      <= 1'b0;
                        state     <= BUSY;
                    end else if (state == DONE && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                BUSY: begin
                    result <= result_nxt;
                    carry  <= step[CHUNK];
                    opa    <= opa >> CHUNK;
                    opb    <= opb >> CHUNK;
                    idx    <= idx + IDXW'(1);
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        cout      <= (cls == CLS_ADD) & step[CHUNK];
                        ovf       <= ovf_nxt;
                        zero      <= (result_nxt == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_addsub.sv
// Directed bench for alu_seq_addsub (WIDTH=16, CHUNK=4) with hand-computed results.
module tb_alu_seq_addsub;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout, ovf, zero, inv_a, inv_b, cin;

    int n_chk  = 0;
    int n_pass = 0;

    alu_seq_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .cout(cout), .ovf(ovf), .zero(zero),
        .inv_a(inv_a), .inv_b(inv_b), .cin(cin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic drive(input logic [15:0] i, input logic [15:0] av, input logic [15:0] bv);
        in_valid = 1'b1;
        instr    = i;
        a        = av;
        b        = bv;
    endtask

    task automatic run_op(input string name, input logic [15:0] i, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] exp_res,
                          input logic ec, input logic eo, input logic ez, input logic [2:0] edec);
        int cnt;
        @(negedge clk);
        chk({name, ".in_ready"}, in_ready, 1);
        drive(i, av, bv);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(cnt);
        chk({name, ".latency"}, cnt, 4);
        chk({name, ".result"}, result, exp_res);
        chk({name, ".cout"}, cout, ec);
        chk({name, ".ovf"}, ovf, eo);
        chk({name, ".zero"}, zero, ez);
        chk({name, ".decode"}, {inv_a, inv_b, cin}, edec);
        out_ready = 1'b1;
        @(negedge clk);
        chk({name, ".drained"}, out_valid, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int   cnt;
        logic seen;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.result", result, 0);
        chk("rst.flags", {cout, ovf, zero, inv_a, inv_b, cin}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.in_ready", in_ready, 1);

        // decode {inv_a, inv_b, cin}
        run_op("sub",   16'hD801, 16'h0003, 16'h0010, 16'h000D, 1, 0, 0, 3'b101);
        run_op("addi",  16'h4000, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 3'b000);
        run_op("andni", 16'h5800, 16'h00FF, 16'h000F, 16'h00F0, 0, 0, 0, 3'b010);
        run_op("subz",  16'hD801, 16'h0001, 16'h0001, 16'h0000, 1, 0, 1, 3'b101);
        run_op("xor",   16'hD802, 16'h1234, 16'h00FF, 16'h12CB, 0, 0, 0, 3'b000);
        run_op("addc",  16'hD800, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 3'b000);

        // Back-pressure, then back-to-back accept on the draining edge.
        @(negedge clk);
        drive(16'hD801, 16'h0003, 16'h0010);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(cnt);
        chk("bp.latency", cnt, 4);
        for (int k = 0; k < 3; k++) begin
            chk("bp.result", result, 16'h000D);
            chk("bp.out_valid", out_valid, 1);
            chk("bp.in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drive(16'h4000, 16'h0100, 16'h0023);
        #1;
        chk("b2b.in_ready", in_ready, 1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_out(cnt);
        chk("b2b.latency", cnt, 4);
        chk("b2b.result", result, 16'h0123);
        chk("b2b.decode", {inv_a, inv_b, cin}, 3'b000);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Flush during the second BUSY cycle; only chunk 0 has been written.
        drive(16'hD800, 16'h1111, 16'h2222);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flbusy.in_ready", in_ready, 1);
        chk("flbusy.result", result, 16'h0003);
        seen = 1'b0;
        repeat (6) begin
            seen |= out_valid;
            @(negedge clk);
        end
        chk("flbusy.no_valid", seen, 0);

        // Flush beats a simultaneous accept.
        flush = 1'b1;
        drive(16'hD801, 16'h0003, 16'h0010);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flacc.inv_a", inv_a, 0);
        seen = 1'b0;
        repeat (6) begin
            seen |= out_valid;
            @(negedge clk);
        end
        chk("flacc.no_valid", seen, 0);

        // Flush in DONE with out_ready high drops flags, keeps result.
        drive(16'hD801, 16'h0001, 16'h0003);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(cnt);
        chk("fldone.cout_before", cout, 1);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("fldone.out_valid", out_valid, 0);
        chk("fldone.cout", cout, 0);
        chk("fldone.result", result, 16'h0002);

        // Asynchronous reset mid-op.
        drive(16'hD801, 16'h0003, 16'h0010);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("arst.inv_a_before", inv_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.result", result, 0);
        chk("arst.out_valid", out_valid, 0);
        chk("arst.flags", {cout, ovf, zero, inv_a, inv_b, cin}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst.in_ready", in_ready, 1);
        run_op("post", 16'hD801, 16'h0003, 16'h0010, 16'h000D, 1, 0, 0, 3'b101);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
